// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - operand/result bundle for serial_adder_ctrl (sub port present when SERIAL_ADDER_SUB_EN is defined)
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder around a 1-bit full-adder cell; SERIAL_ADDER_SUB_EN adds a subtract mode
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  logic axb, ab, cx;

  xor g_axb (axb, a, b);
  xor g_s   (s, axb, c);
  and g_ab  (ab, a, b);
  and g_cx  (cx, c, axb);
  or  g_co  (co, ab, cx);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  io
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MSB_IN = CNT_W'(WIDTH - 2);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh_a, sh_b, sum_r;
  logic [CNT_W-1:0] cnt;
  logic             carry, cmsb, cout_r, ovf_r;
  logic             fa_s, fa_co;
  logic             accept, last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  serial_adder_fa u_fa (
    .a  (sh_a[0]),
    .b  (sh_b[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt == CNT_LAST);

`ifdef SERIAL_ADDER_SUB_EN
  // a - b computed as a + ~b + 1; cout=1 then means no borrow
  assign b_load = io.sub ? ~io.b : io.b;
  assign c_load = io.sub ? 1'b1 : io.cin;
`else
  assign b_load = io.b;
  assign c_load = io.cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (io.start) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (io.start) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cmsb   <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      sh_a   <= io.a;
      sh_b   <= b_load;
      carry  <= c_load;
      sum_r  <= '0;
      cnt    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (state == SHIFT) begin
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      sum_r <= {fa_s, sum_r[WIDTH-1:1]};
      carry <= fa_co;
      cnt   <= cnt + 1'b1;
      // carry leaving bit WIDTH-2 is the carry into the MSB
      if (cnt == CNT_MSB_IN) begin
        cmsb <= fa_co;
      end
      if (last) begin
        cout_r <= fa_co;
        ovf_r  <= cmsb ^ fa_co;
      end
    end
  end

  assign io.busy = (state == SHIFT);
  assign io.done = (state == DONE);
  assign io.sum  = sum_r;
  assign io.cout = cout_r;
  assign io.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl against an arithmetic reference model
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [W+1:0] exp_q[$];

  serial_adder_ctrl_if #(.WIDTH(W)) io ();

  serial_adder_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  // returns {ovf, cout, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    logic         v;
    bb   = s ? ~b : b;
    cc   = s ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
    v    = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {v, full[W], full[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && io.done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending result");
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("sum",  32'(io.sum),  32'(e[W-1:0]));
        check("cout", 32'(io.cout), 32'(e[W]));
        check("ovf",  32'(io.ovf),  32'(e[W+1]));
      end
    end
  end

  task automatic set_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    io.sub = s;
`else
    if (s) $display("note: subtract requested without sub port");
`endif
  endtask

  // drives start away from the edge; start is sampled on the next posedge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s, input bit push);
    io.start = 1'b1;
    io.a     = a;
    io.b     = b;
    io.cin   = c;
    set_sub(s);
    if (push) exp_q.push_back(model(a, b, c, s));
    @(posedge clk);
    #1;
    io.start = 1'b0;
    io.a     = W'($urandom);
    io.b     = W'($urandom);
    io.cin   = 1'($urandom);
  endtask

  task automatic wait_done(output int busy_cycles);
    int n;
    busy_cycles = 0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (io.done) break;
      if (io.busy) busy_cycles++;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done in %0d cycles want done", n);
    end
  endtask

  initial begin
    int bc;
    io.start = 1'b0;
    io.a     = '0;
    io.b     = '0;
    io.cin   = 1'b0;
    set_sub(1'b0);

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(io.busy), 0);
    check("rst_done", 32'(io.done), 0);
    check("rst_sum",  32'(io.sum),  0);
    check("rst_cout", 32'(io.cout), 0);
    check("rst_ovf",  32'(io.ovf),  0);
    rst = 1'b0;
    @(negedge clk);

    issue(8'h35, 8'h1A, 1'b0, 1'b0, 1'b1);
    wait_done(bc);
    check("latency_busy", 32'(bc), W);
    check("direct_sum", 32'(io.sum), 32'h4F);
    @(negedge clk);
    check("done_one_cycle", 32'(io.done), 0);
    check("sum_held", 32'(io.sum), 32'h4F);

    issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_done(bc);
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_done(bc);
    issue(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_done(bc);
    @(negedge clk);

    // second start while busy must be ignored
    issue(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    io.start = 1'b1;
    io.a     = 8'hAA;
    io.b     = 8'h55;
    @(negedge clk);
    io.start = 1'b0;
    wait_done(bc);
    // back-to-back: start during the DONE cycle
    issue(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
    wait_done(bc);
    check("b2b_busy", 32'(bc), W);
    @(negedge clk);

    // reset mid-shift aborts without a done pulse
    issue(8'h35, 8'h1A, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(io.busy), 0);
    check("abort_sum",  32'(io.sum),  0);
    check("abort_done", 32'(io.done), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_done(bc);
    @(negedge clk);

    // rst wins over start on the same edge
    rst      = 1'b1;
    io.start = 1'b1;
    @(negedge clk);
    check("rst_pri_busy", 32'(io.busy), 0);
    rst      = 1'b0;
    io.start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pri_idle", 32'(io.busy), 0);

`ifdef SERIAL_ADDER_SUB_EN
    issue(8'h10, 8'h01, 1'b0, 1'b1, 1'b1);
    wait_done(bc);
    issue(8'h00, 8'h01, 1'b0, 1'b1, 1'b1);
    wait_done(bc);
    issue(8'h80, 8'h01, 1'b1, 1'b1, 1'b1);
    wait_done(bc);
    @(negedge clk);
`endif

    for (int i = 0; i < 40; i++) begin
      int gap;
      logic s;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      issue(W'($urandom), W'($urandom), 1'($urandom), s, 1'b1);
      wait_done(bc);
    end

    repeat (W + 4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
